reverb_sched: RTL and testbench

- Sample-rate scheduler and bypass controller for the reverb datapath.
- Generates the audio sample tick from clk_50m and latches the dry synth sample on each tick.
- Issues the sample to the reverb with a one-cycle ready strobe, then waits for the reverb's ready_out with a timeout.
- Crossfades wet/dry on reverb_on changes to avoid clicks, and delivers one output sample per tick to the DAC path.

---
 rtl/reverb_sched.sv | 167 ++++++++++++++++
 tb/tb_reverb_sched.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/reverb_sched.sv
// Sample-rate scheduler and wet/dry crossfade controller for the reverb datapath.
// Define REVERB_SCHED_FADE_EN for a gradual gain ramp; otherwise the gain switches hard.
module reverb_sched #(
  parameter int CLK_DIV    = 1042,
  parameter int TIMEOUT    = 512,
  parameter int FADE_SHIFT = 6
) (
  input  logic               clk_50m,
  input  logic               rst_n,
  input  logic               reverb_on,
  input  logic signed [15:0] src_sample,
  output logic               sample_tick,
  output logic signed [15:0] fx_signal_in,
  output logic               fx_ready_in,
  output logic               fx_reverb_on,
  input  logic signed [15:0] fx_signal_out,
  input  logic               fx_ready_out,
  output logic signed [15:0] dac_sample,
  output logic               dac_valid,
  output logic               err_timeout
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int AW = 16 + FADE_SHIFT + 2;
  localparam logic [FADE_SHIFT:0] M_G = (FADE_SHIFT + 1)'(1 << FADE_SHIFT);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_MIX, S_OUT} state_t;

  state_t                  state_r, state_s;
  logic [CW-1:0]           count_r;
  logic [TW-1:0]           to_cnt_r;
  logic [FADE_SHIFT:0]     g_r, g_next_s, target_s;
  logic signed [15:0]      dry_r, wet_r, dac_next_s;
  logic signed [FADE_SHIFT+1:0] gw_s, gd_s;
  logic signed [AW-1:0]    acc_s, shr_s;
  logic                    fx_on_s, enter_issue_s, bypass_s, take_wet_s, timeout_s;

  // Free-running sample-rate divider; the tick is registered one count early.
  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      count_r     <= '0;
      sample_tick <= 1'b0;
    end else begin
      count_r     <= (count_r == CW'(CLK_DIV - 1)) ? '0 : count_r + CW'(1);
      sample_tick <= (count_r == CW'(CLK_DIV - 2));
    end
  end

  // Wet-path enable and next gain; the fade build keeps the reverb alive until g drains.
  always_comb begin
    target_s = reverb_on ? M_G : '0;
`ifdef REVERB_SCHED_FADE_EN
    fx_on_s = reverb_on | (g_r != '0);
    if (g_r < target_s) begin
      g_next_s = g_r + (FADE_SHIFT + 1)'(1);
    end else if (g_r > target_s) begin
      g_next_s = g_r - (FADE_SHIFT + 1)'(1);
    end else begin
      g_next_s = g_r;
    end
`else
    fx_on_s  = reverb_on;
    g_next_s = target_s;
`endif
  end

  // Weighted mix; the weights sum to M so the shifted result always fits in 16 bits.
  always_comb begin
    gw_s       = signed'({1'b0, g_r});
    gd_s       = signed'({1'b0, M_G - g_r});
    acc_s      = AW'(wet_r) * AW'(gw_s) + AW'(dry_r) * AW'(gd_s);
    shr_s      = acc_s >>> FADE_SHIFT;
    dac_next_s = shr_s[15:0];
  end

  // FSM state register.
  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state and per-cycle datapath controls.
  always_comb begin
    state_s       = state_r;
    enter_issue_s = 1'b0;
    bypass_s      = 1'b0;
    take_wet_s    = 1'b0;
    timeout_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (sample_tick) begin
          if (fx_on_s) begin
            state_s       = S_ISSUE;
            enter_issue_s = 1'b1;
          end else begin
            state_s  = S_MIX;
            bypass_s = 1'b1;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ISSUE, S_WAIT: begin
        if (fx_ready_out) begin
          state_s    = S_MIX;
          take_wet_s = 1'b1;
        end else if ((state_r == S_WAIT) && (to_cnt_r == TW'(TIMEOUT))) begin
          state_s   = S_MIX;
          timeout_s = 1'b1;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_MIX:   state_s = S_OUT;
      S_OUT:   state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Sample latches, reverb handshake, timeout tracking, gain and DAC outputs.
  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      dry_r        <= '0;
      wet_r        <= '0;
      g_r          <= '0;
      to_cnt_r     <= '0;
      fx_signal_in <= '0;
      fx_ready_in  <= 1'b0;
      fx_reverb_on <= 1'b0;
      dac_sample   <= '0;
      dac_valid    <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      fx_reverb_on <= fx_on_s;
      fx_ready_in  <= enter_issue_s;
      dac_valid    <= (state_r == S_MIX);
      if (state_r == S_IDLE && sample_tick) begin
        dry_r <= src_sample;
      end
      if (enter_issue_s) begin
        fx_signal_in <= src_sample;
        to_cnt_r     <= '0;
      end else if (state_r == S_ISSUE || state_r == S_WAIT) begin
        to_cnt_r <= to_cnt_r + TW'(1);
      end
      if (bypass_s) begin
        wet_r <= src_sample;
      end else if (take_wet_s) begin
        wet_r <= fx_signal_out;
      end else if (timeout_s) begin
        wet_r       <= dry_r;
        err_timeout <= 1'b1;
      end
      if (state_r == S_MIX) begin
        dac_sample <= dac_next_s;
      end
      if (state_r == S_OUT) begin
        g_r <= g_next_s;
      end
    end
  end

endmodule

// File: tb/tb_reverb_sched.sv
// Directed bench for reverb_sched with a stub reverb; expectations follow
// REVERB_SCHED_FADE_EN the same way the design does.
module tb_reverb_sched;

  localparam int CLK_DIV    = 50;
  localparam int TIMEOUT    = 20;
  localparam int FADE_SHIFT = 2;

  logic               clk_50m = 1'b0;
  logic               rst_n = 1'b0;
  logic               reverb_on = 1'b0;
  logic signed [15:0] src_sample = 16'sd0;
  logic signed [15:0] fx_signal_out = 16'sd0;
  logic               fx_ready_out = 1'b0;
  logic               sample_tick, fx_ready_in, fx_reverb_on, dac_valid, err_timeout;
  logic signed [15:0] fx_signal_in, dac_sample;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int tick_cyc = 0;
  int n_dac = 0;
  int n_issue = 0;
  int stub_delay = -1;
  int since = 1000;
  bit spur_en = 1'b0;

  reverb_sched #(.CLK_DIV(CLK_DIV), .TIMEOUT(TIMEOUT), .FADE_SHIFT(FADE_SHIFT)) dut (
    .clk_50m(clk_50m), .rst_n(rst_n), .reverb_on(reverb_on), .src_sample(src_sample),
    .sample_tick(sample_tick), .fx_signal_in(fx_signal_in), .fx_ready_in(fx_ready_in),
    .fx_reverb_on(fx_reverb_on), .fx_signal_out(fx_signal_out), .fx_ready_out(fx_ready_out),
    .dac_sample(dac_sample), .dac_valid(dac_valid), .err_timeout(err_timeout)
  );

  always #10 clk_50m = ~clk_50m;

  always @(posedge clk_50m) cyc <= cyc + 1;

  // Event monitor: tick time and strobe counts, sampled mid-cycle.
  always @(negedge clk_50m) begin
    if (sample_tick) tick_cyc = cyc;
    if (dac_valid) n_dac = n_dac + 1;
    if (fx_ready_in) n_issue = n_issue + 1;
  end

  // Stub reverb: answers stub_delay cycles after each strobe, optional stray strobes later.
  always @(negedge clk_50m) begin
    if (fx_ready_in) since = 0;
    else if (since < 1000) since = since + 1;
    fx_ready_out = (since == stub_delay) || (spur_en && (since == 10 || since == 15));
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic wait_dac(output logic signed [15:0] v, output int lat, output bit ok);
    ok = 1'b0;
    v = 16'sd0;
    lat = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk_50m);
      if (dac_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      v = dac_sample;
      lat = cyc - tick_cyc;
    end
    @(negedge clk_50m);
  endtask

  task automatic next_dac(input string tag, input logic signed [15:0] exp_v, input int exp_lat);
    logic signed [15:0] v;
    int lat;
    bit ok;
    wait_dac(v, lat, ok);
    check($sformatf("%s_seen", tag), {31'd0, ok}, 32'd1);
    if (ok) begin
      check($sformatf("%s_val", tag), v, exp_v);
      check($sformatf("%s_lat", tag), lat, exp_lat);
    end
  endtask

`ifdef REVERB_SCHED_FADE_EN
  localparam int FADE = 1;
`else
  localparam int FADE = 0;
`endif

  int in_vals[2][6] = '{'{1000, -1000, -1000, -1000, -1000, -1000},
                        '{1000, 500, 0, -500, -1000, -1000}};
  int out_vals[2][5] = '{'{1000, 1000, 1000, 1000, 1000}, '{-1000, -500, 0, 500, 1000}};
  int out_lats[2][5] = '{'{2, 2, 2, 2, 2}, '{6, 6, 6, 6, 2}};

  initial begin
    int nd, ni, n;
    logic signed [15:0] v;
    int lat;
    bit ok;

    // Reset state
    reverb_on = 1'b0;
    src_sample = 16'sd1234;
    repeat (3) @(negedge clk_50m);
    check("rst_tick", {31'd0, sample_tick}, 32'd0);
    check("rst_ready_in", {31'd0, fx_ready_in}, 32'd0);
    check("rst_fx_on", {31'd0, fx_reverb_on}, 32'd0);
    check("rst_dac_valid", {31'd0, dac_valid}, 32'd0);
    check("rst_dac_sample", dac_sample, 32'd0);
    check("rst_fx_sig", fx_signal_in, 32'd0);
    check("rst_err", {31'd0, err_timeout}, 32'd0);
    rst_n = 1'b1;

    // Tick period
    n = 0;
    while (!sample_tick && n < 200) begin @(negedge clk_50m); n++; end
    n = 0;
    do begin @(negedge clk_50m); n++; end while (!sample_tick && n < 200);
    check("tick_period", n, CLK_DIV);

    // 1. Bypass
    next_dac("bypass", 16'sd1234, 2);
    #1 check("bypass_no_issue", n_issue, 32'd0);
    check("bypass_fx_on", {31'd0, fx_reverb_on}, 32'd0);

    // 2. Fade-in from reset with wet path requested
    @(negedge clk_50m) rst_n = 1'b0;
    reverb_on = 1'b1;
    src_sample = 16'sd1000;
    fx_signal_out = -16'sd1000;
    stub_delay = 3;
    repeat (3) @(negedge clk_50m);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) next_dac($sformatf("fadein%0d", i), 16'(in_vals[FADE][i]), 6);
    check("fadein_fx_on", {31'd0, fx_reverb_on}, 32'd1);

    // 3. Fade-out
    reverb_on = 1'b0;
    #1 ni = n_issue;
    for (int i = 0; i < 5; i++) next_dac($sformatf("fadeout%0d", i), 16'(out_vals[FADE][i]), out_lats[FADE][i]);
    check("fadeout_fx_on", {31'd0, fx_reverb_on}, 32'd0);
    #1 check("fadeout_issues", n_issue - ni, FADE ? 32'd4 : 32'd0);

    // 4. Timeout, after ramping back to full wet
    reverb_on = 1'b1;
    for (int i = 0; i < (FADE ? 4 : 1); i++) wait_dac(v, lat, ok);
    stub_delay = -1;
    src_sample = 16'sd777;
    next_dac("timeout", 16'sd777, TIMEOUT + 3);
    check("timeout_err", {31'd0, err_timeout}, 32'd1);
    stub_delay = 3;
    next_dac("after_to", -16'sd1000, 6);
    check("err_sticky", {31'd0, err_timeout}, 32'd1);

    // 5. Zero-latency answers plus stray strobes
    stub_delay = 0;
    spur_en = 1'b1;
    fx_signal_out = 16'sd400;
    #1 nd = n_dac;
    next_dac("zlat0", 16'sd400, 3);
    next_dac("zlat1", 16'sd400, 3);
    repeat (20) @(negedge clk_50m);
    #1 check("zlat_count", n_dac - nd, 32'd2);
    spur_en = 1'b0;

    // 6. Reset during WAIT
    stub_delay = 10;
    n = 0;
    while (!fx_ready_in && n < 200) begin @(negedge clk_50m); n++; end
    check("rw_issue_seen", {31'd0, fx_ready_in}, 32'd1);
    repeat (2) @(negedge clk_50m);
    rst_n = 1'b0;
    @(negedge clk_50m);
    check("rw_fx_on", {31'd0, fx_reverb_on}, 32'd0);
    check("rw_err", {31'd0, err_timeout}, 32'd0);
    check("rw_dac_sample", dac_sample, 32'd0);
    check("rw_fx_sig", fx_signal_in, 32'd0);
    #1 nd = n_dac;
    repeat (2) @(negedge clk_50m);
    rst_n = 1'b1;
    stub_delay = 3;
    src_sample = 16'sd1000;
    fx_signal_out = -16'sd1000;
    repeat (20) @(negedge clk_50m);
    #1 check("rw_no_dac", n_dac - nd, 32'd0);
    next_dac("rw_resume", 16'sd1000, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
